// File: rtl/mux_valve_sequencer.sv
// Binary-tree microfluidic multiplexer sequencer.
// Opens a route from one of 2^LEVELS leaves to the root, break-before-make:
// all valves close for SETTLE cycles, the new pattern is applied for SETTLE
// cycles, and only then is the route reported active. Release drains (all
// closed) for SETTLE cycles before going idle.
// Note: "release" is a reserved word, so the release input is release_route.
module mux_valve_sequencer #(
  parameter int LEVELS = 6,
  parameter int SETTLE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [LEVELS-1:0] req_addr,
  output logic              req_ready,
  input  logic              release_route,
  output logic [LEVELS-1:0] ctrl_0,
  output logic [LEVELS-1:0] ctrl_1,
  output logic              active,
  output logic              route_done,
  output logic [LEVELS-1:0] cur_addr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLOSE  = 3'd1,
    OPEN   = 3'd2,
    ACTIVE = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  // Reload value of the settle counter; SETTLE is legal over 1..255 so this fits.
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  state_t     state;
  logic [7:0] cnt;

  logic accept;
  logic same_addr;
  logic start_route;
  logic start_drain;
  logic settled;
  logic close_all;
  logic apply;

  // Transition decisions shared by the FSM and the valve registers.
  always_comb begin
    accept      = req_valid & req_ready;
    same_addr   = (req_addr == cur_addr);
    start_route = accept & ((state == IDLE) | ((state == ACTIVE) & ~same_addr));
    start_drain = (state == ACTIVE) & release_route & ~req_valid;
    settled     = (cnt == 8'd0);
    close_all   = start_route | start_drain;
    apply       = (state == CLOSE) & settled;
  end

  // Sequencer FSM: state, settle counter, latched address and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      cur_addr   <= '0;
      active     <= 1'b0;
      route_done <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      route_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_route) begin
            state     <= CLOSE;
            cnt       <= SETTLE_M1;
            cur_addr  <= req_addr;
            req_ready <= 1'b0;
          end
        end
        CLOSE: begin
          if (settled) begin
            state <= OPEN;
            cnt   <= SETTLE_M1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        OPEN: begin
          if (settled) begin
            state      <= ACTIVE;
            active     <= 1'b1;
            route_done <= 1'b1;
            req_ready  <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ACTIVE: begin
          // A request outranks a simultaneous release.
          if (start_route) begin
            state     <= CLOSE;
            cnt       <= SETTLE_M1;
            cur_addr  <= req_addr;
            active    <= 1'b0;
            req_ready <= 1'b0;
          end else if (accept) begin
            route_done <= 1'b1;
          end else if (start_drain) begin
            state     <= DRAIN;
            cnt       <= SETTLE_M1;
            active    <= 1'b0;
            req_ready <= 1'b0;
          end
        end
        DRAIN: begin
          if (settled) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          active    <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // One control-line pair per tree level. Level i (ctrl bit i-1) steers on
  // address bit LEVELS-i, so the root level uses the address MSB.
  for (genvar g = 0; g < LEVELS; g++) begin : g_lvl
    logic sel_bit;
    assign sel_bit = cur_addr[LEVELS-1-g];

    // Valve pair register: closes on any route change or drain, takes the
    // addressed pattern once the close phase has settled, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctrl_0[g] <= 1'b1;
        ctrl_1[g] <= 1'b1;
      end else if (close_all) begin
        ctrl_0[g] <= 1'b1;
        ctrl_1[g] <= 1'b1;
      end else if (apply) begin
        ctrl_0[g] <= sel_bit;
        ctrl_1[g] <= ~sel_bit;
      end
    end
  end

endmodule

// File: tb/tb_mux_valve_sequencer.sv
// Bench for mux_valve_sequencer (LEVELS=6, SETTLE=4): directed sequences with
// literal expectations, then random traffic, all checked every cycle against a
// timestamp-based model of the route timeline.
module tb_mux_valve_sequencer;
  localparam int L = 6;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic [L-1:0] req_addr = '0;
  logic         req_ready;
  logic         release_route = 1'b0;
  logic [L-1:0] ctrl_0, ctrl_1, cur_addr;
  logic         active, route_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  mux_valve_sequencer #(.LEVELS(L), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .release_route(release_route),
    .ctrl_0(ctrl_0), .ctrl_1(ctrl_1), .active(active),
    .route_done(route_done), .cur_addr(cur_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode 0 idle, 1 route started at cycle m_t0, 2 drain started at m_t0.
  // Everything else is derived from the distance to m_t0.
  int           m_mode = 0;
  int           m_t0 = 0;
  int           m_done_at = -1;
  logic [L-1:0] m_addr = '0;

  function automatic logic [L-1:0] pat(input logic [L-1:0] a);
    logic [L-1:0] p;
    p = '0;
    for (int i = 1; i <= L; i++) p[i-1] = a[L-i];
    return p;
  endfunction

  task automatic model_eval(input int c, output logic [L-1:0] e0, output logic [L-1:0] e1,
                            output logic ea, output logic ed, output logic er);
    int d;
    d = c - m_t0;
    e0 = '1; e1 = '1; ea = 1'b0; ed = 1'b0; er = 1'b1;
    if (m_mode == 1) begin
      if (d <= S) er = 1'b0;
      else begin
        e0 = pat(m_addr);
        e1 = ~pat(m_addr);
        if (d <= 2*S) er = 1'b0;
        else begin
          ea = 1'b1;
          ed = (d == 2*S+1) || (c == m_done_at);
        end
      end
    end else if (m_mode == 2 && d <= S) begin
      er = 1'b0;
    end
  endtask

  // Model update: inputs of cycle cyc are consumed at the edge ending it.
  always @(posedge clk) begin
    logic [L-1:0] u0, u1;
    logic ua, ud, ur;
    if (!rst_n) begin
      m_mode = 0; m_addr = '0; m_done_at = -1;
    end else begin
      model_eval(cyc, u0, u1, ua, ud, ur);
      if (req_valid && ur) begin
        if (ua && req_addr == m_addr) m_done_at = cyc + 1;
        else begin m_mode = 1; m_t0 = cyc; m_addr = req_addr; m_done_at = -1; end
      end else if (release_route && ua) begin
        m_mode = 2; m_t0 = cyc; m_done_at = -1;
      end
    end
    cyc++;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [L-1:0] e0, e1, ecur;
    logic ea, ed, er;
    model_eval(cyc, e0, e1, ea, ed, er);
    ecur = m_addr;
    if (!rst_n) begin
      e0 = '1; e1 = '1; ea = 1'b0; ed = 1'b0; ecur = '0;
    end
    check("m_ctrl_0", 32'(ctrl_0), 32'(e0));
    check("m_ctrl_1", 32'(ctrl_1), 32'(e1));
    check("m_active", 32'(active), 32'(ea));
    check("m_route_done", 32'(route_done), 32'(ed));
    check("m_cur_addr", 32'(cur_addr), 32'(ecur));
    if (rst_n) check("m_req_ready", 32'(req_ready), 32'(er));
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [L-1:0] a);
    req_valid = 1'b1; req_addr = a;
    step(1);
    req_valid = 1'b0;
  endtask

  initial begin
    // reset then idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step(2);
    check("idle_ctrl_0", 32'(ctrl_0), 32'h3f);
    check("idle_ctrl_1", 32'(ctrl_1), 32'h3f);
    check("idle_active", 32'(active), 32'h0);
    check("idle_ready", 32'(req_ready), 32'h1);

    // addr 0: closed T+1..T+4, open T+5..T+8, active T+9
    accept(6'd0);
    check("a0_t1_ctrl_0", 32'(ctrl_0), 32'h3f);
    check("a0_t1_ready", 32'(req_ready), 32'h0);
    step(3);
    check("a0_t4_ctrl_0", 32'(ctrl_0), 32'h3f);
    step(1);
    check("a0_t5_ctrl_0", 32'(ctrl_0), 32'h00);
    check("a0_t5_ctrl_1", 32'(ctrl_1), 32'h3f);
    step(3);
    check("a0_t8_active", 32'(active), 32'h0);
    step(1);
    check("a0_t9_active", 32'(active), 32'h1);
    check("a0_t9_done", 32'(route_done), 32'h1);
    step(1);
    check("a0_t10_done", 32'(route_done), 32'h0);

    // addr 37 from active: break-before-make
    accept(6'd37);
    check("a37_t1_active", 32'(active), 32'h0);
    check("a37_t1_ctrl_1", 32'(ctrl_1), 32'h3f);
    step(4);
    check("a37_t5_ctrl_1", 32'(ctrl_1), 32'b010110);
    check("a37_t5_ctrl_0", 32'(ctrl_0), 32'b101001);
    step(4);
    check("a37_t9_active", 32'(active), 32'h1);
    check("a37_t9_ctrl_1", 32'(ctrl_1), 32'b010110);

    // switch to addr 2
    accept(6'd2);
    check("a2_t1_active", 32'(active), 32'h0);
    step(3);
    check("a2_t4_ctrl_0", 32'(ctrl_0), 32'h3f);
    step(1);
    check("a2_t5_ctrl_1", 32'(ctrl_1), 32'b101111);
    check("a2_t5_ctrl_0", 32'(ctrl_0), 32'b010000);
    step(4);
    check("a2_t9_active", 32'(active), 32'h1);

    // same-address request: stay active, one-cycle pulse
    accept(6'd2);
    check("same_done", 32'(route_done), 32'h1);
    check("same_active", 32'(active), 32'h1);
    check("same_ctrl_0", 32'(ctrl_0), 32'b010000);
    step(1);
    check("same_done_clr", 32'(route_done), 32'h0);

    // request and release together: request wins
    release_route = 1'b1;
    accept(6'd5);
    release_route = 1'b0;
    check("rr_t1_active", 32'(active), 32'h0);
    check("rr_t1_cur", 32'(cur_addr), 32'd5);
    step(8);
    check("rr_t9_active", 32'(active), 32'h1);
    check("rr_t9_ctrl_0", 32'(ctrl_0), 32'b101000);
    check("rr_t9_ctrl_1", 32'(ctrl_1), 32'b010111);

    // plain release: 4 cycles drain then idle
    release_route = 1'b1;
    step(1);
    release_route = 1'b0;
    check("rel_t1_ctrl_0", 32'(ctrl_0), 32'h3f);
    check("rel_t1_active", 32'(active), 32'h0);
    step(3);
    check("rel_t4_ready", 32'(req_ready), 32'h0);
    step(1);
    check("rel_t5_ready", 32'(req_ready), 32'h1);

    // release in idle is ignored
    release_route = 1'b1;
    step(1);
    release_route = 1'b0;
    check("idle_rel_ready", 32'(req_ready), 32'h1);
    check("idle_rel_ctrl", 32'(ctrl_1), 32'h3f);

    // reset during OPEN: asynchronous close, then full resequence
    accept(6'd37);
    step(5);
    check("rst_open_ctrl_0", 32'(ctrl_0), 32'b101001);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_ctrl_0", 32'(ctrl_0), 32'h3f);
    check("rst_async_ctrl_1", 32'(ctrl_1), 32'h3f);
    check("rst_async_cur", 32'(cur_addr), 32'h0);
    step(2);
    rst_n = 1'b1;
    accept(6'd37);
    check("post_rst_t1_ctrl", 32'(ctrl_0), 32'h3f);
    step(7);
    check("post_rst_t8_active", 32'(active), 32'h0);
    step(1);
    check("post_rst_t9_active", 32'(active), 32'h1);

    // random traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 5) == 0);
      req_addr = ($urandom_range(0, 2) == 0) ? m_addr : L'($urandom);
      release_route = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 599) != 0);
      step(1);
    end
    req_valid = 1'b0;
    release_route = 1'b0;
    rst_n = 1'b1;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
